// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: slot encodings,
// digit-mask constants, parameter legality check and small helpers.
package display_scan_ctrl_pkg;

    // Digit slot encodings as presented on the display select lines.
    typedef enum logic [1:0] {
        SEL_DIG1 = 2'b00,
        SEL_DIG2 = 2'b01,
        SEL_DIG3 = 2'b10,
        SEL_DIG4 = 2'b11
    } slot_e;

    // Visibility masks: bit3 = digit 1 ... bit0 = digit 4.
    localparam logic [3:0] MASK_ALL   = 4'b1111;
    localparam logic [3:0] MASK_HOURS = 4'b1100;
    localparam logic [3:0] MASK_MINS  = 4'b0011;
    localparam logic [3:0] MASK_NONE  = 4'b0000;

    // A slot must be at least two cycles long and the dead time must leave
    // at least one lit cycle in every slot.
    function automatic bit scan_params_ok(input int scan_div, input int dead_cycles);
        return (scan_div >= 2) && (dead_cycles >= 0) && (dead_cycles < scan_div);
    endfunction

    // Round-robin digit order 1 -> 2 -> 3 -> 4 -> 1.
    function automatic slot_e next_slot(input slot_e s);
        slot_e n;
        case (s)
            SEL_DIG1: n = SEL_DIG2;
            SEL_DIG2: n = SEL_DIG3;
            SEL_DIG3: n = SEL_DIG4;
            default:  n = SEL_DIG1;
        endcase
        return n;
    endfunction

    // Which digits are lit for a given edit mode and blink phase. During the
    // dark half of the blink the pair under edit is hidden; hours win when
    // both edit levels are high, so the minutes pair stays visible.
    function automatic logic [3:0] vis_mask(input logic edit_hours,
                                            input logic edit_minutes,
                                            input logic ph);
        logic [3:0] m;
        if (ph)
            m = MASK_ALL;
        else if (edit_hours)
            m = MASK_MINS;
        else if (edit_minutes)
            m = MASK_HOURS;
        else
            m = MASK_ALL;
        return m;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control bundle between the scan controller and its neighbours: blink and
// edit inputs in, display mux controls out.
interface display_scan_ctrl_if;

    logic       i_Tick_Half_Sec;
    logic       i_Edit_Hours;
    logic       i_Edit_Minutes;
    logic [1:0] o_Select;
    logic [3:0] o_Enable_Digits;
    logic       o_Enable_Dot;
    logic       o_Frame;

    // Controller side: consumes strobes/levels, drives the display controls.
    modport master (
        input  i_Tick_Half_Sec,
        input  i_Edit_Hours,
        input  i_Edit_Minutes,
        output o_Select,
        output o_Enable_Digits,
        output o_Enable_Dot,
        output o_Frame
    );

    // Surrounding side: timebase/edit logic and the display mux.
    modport slave (
        output i_Tick_Half_Sec,
        output i_Edit_Hours,
        output i_Edit_Minutes,
        input  o_Select,
        input  o_Enable_Digits,
        input  o_Enable_Dot,
        input  o_Frame
    );

endinterface

// File: rtl/display_scan_ctrl_prescaler.sv
// Free-running modulo-DIV counter with a wrap strobe. Exposes the value the
// counter will hold after the next edge so a parent can register outputs
// that line up with the counter state in the same cycle.
module display_scan_ctrl_prescaler #(
    parameter int DIV   = 2500,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    output logic [CNT_W-1:0] o_Count_Next,
    output logic             o_Wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_wrap;

    assign w_wrap       = (r_count == LAST);
    assign w_count_next = w_wrap ? '0 : r_count + 1'b1;

    // Count up every cycle, wrapping to zero after the last count.
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            r_count <= '0;
        else
            r_count <= w_count_next;
    end

    assign o_Count_Next = w_count_next;
    assign o_Wrap       = w_wrap;

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller for the 4-digit display mux: steps through the digits,
// blanks the start of each slot against ghosting, blinks the colon and
// blinks the pair under edit.
//
// slot     | meaning
// SEL_DIG1 | digit 1 (hours tens) selected; frame strobe on its first cycle
// SEL_DIG2 | digit 2 (hours units); the dot shows here
// SEL_DIG3 | digit 3 (minutes tens)
// SEL_DIG4 | digit 4 (minutes units)
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV    = 2500,
    parameter int DEAD_CYCLES = 50
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    display_scan_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    if (!scan_params_ok(SCAN_DIV, DEAD_CYCLES)) begin : g_param_err
        $error("display_scan_ctrl: need SCAN_DIV >= 2 and 0 <= DEAD_CYCLES < SCAN_DIV");
    end

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wrap;
    logic             w_dead_next;

    slot_e            r_sel;
    logic             r_ph;
    logic             r_ed_q;
    logic [3:0]       r_enable;
    logic             r_dot;
    logic             r_frame;

    slot_e            w_sel_next;
    logic             w_ph_next;
    logic             w_edit;
    logic [3:0]       w_mask;
    logic             w_dot;
    logic [3:0]       w_enable_next;
    logic             w_dot_next;
    logic             w_frame_next;

    display_scan_ctrl_prescaler #(
        .DIV   (SCAN_DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .o_Count_Next (w_cnt_next),
        .o_Wrap       (w_wrap)
    );

    // Dead time is judged on the count the slot will have next cycle, so the
    // registered enables blank exactly the first DEAD_CYCLES of each slot.
    if (DEAD_CYCLES == 0) begin : g_no_dead
        assign w_dead_next = 1'b0;
    end else begin : g_dead
        assign w_dead_next = (w_cnt_next < CNT_W'(DEAD_CYCLES));
    end

    // Next slot, blink phase and the display controls that go with them.
    always_comb begin
        w_sel_next    = r_sel;
        w_ph_next     = r_ph;
        w_edit        = bus.i_Edit_Hours | bus.i_Edit_Minutes;
        w_mask        = MASK_ALL;
        w_dot         = 1'b0;
        w_enable_next = MASK_NONE;
        w_dot_next    = 1'b0;
        w_frame_next  = 1'b0;

        if (w_wrap)
            w_sel_next = next_slot(r_sel);

        // Entering edit restarts the blink on the visible half, even if a
        // half-second tick lands in the same cycle.
        if (w_edit && !r_ed_q)
            w_ph_next = 1'b1;
        else if (bus.i_Tick_Half_Sec)
            w_ph_next = ~r_ph;

        w_mask = vis_mask(bus.i_Edit_Hours, bus.i_Edit_Minutes, w_ph_next);
        w_dot  = w_edit ? 1'b1 : w_ph_next;

        if (!w_dead_next) begin
            w_enable_next = w_mask;
            w_dot_next    = w_dot;
        end

        w_frame_next = (w_sel_next == SEL_DIG1) && (w_cnt_next == '0);
    end

    // State and registered outputs; reset parks everything dark on digit 1.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_sel    <= SEL_DIG1;
            r_ph     <= 1'b1;
            r_ed_q   <= 1'b0;
            r_enable <= MASK_NONE;
            r_dot    <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_sel    <= w_sel_next;
            r_ph     <= w_ph_next;
            r_ed_q   <= w_edit;
            r_enable <= w_enable_next;
            r_dot    <= w_dot_next;
            r_frame  <= w_frame_next;
        end
    end

    assign bus.o_Select        = r_sel;
    assign bus.o_Enable_Digits = r_enable;
    assign bus.o_Enable_Dot    = r_dot;
    assign bus.o_Frame         = r_frame;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Sequential scan controller sitting directly upstream of the combinational 4-digit `display` mux. It generates the `display` control inputs:
- digit select (`i_Select`)
- digit-enable mask (`i_Enable_Digits`)
- colon/dot enable (`i_Enable_Dot`)

It time-multiplexes the four digits, inserts anti-ghosting dead time, blinks the colon, and blinks the hours or minutes pair during time-set edit mode.

Parameters:
- SCAN_DIV, 2500, clock cycles per digit slot; must be ≥ 2.
- DEAD_CYCLES, 50, cycles at the start of each slot with all digits blanked; must satisfy 0 ≤ DEAD_CYCLES < SCAN_DIV.

Ports:
- i_Clk  in  1  system clock; single clock domain.
- i_Reset  in  1  synchronous, active-high reset.
- i_Tick_Half_Sec  in  1  one-cycle strobe every 0.5 s from the timebase.
- i_Edit_Hours  in  1  level; hours pair (digits 1,2) is being edited.
- i_Edit_Minutes  in  1  level; minutes pair (digits 3,4) is being edited.
- o_Select  out  2  digit select to `display`; 00 = digit 1 … 11 = digit 4.
- o_Enable_Digits  out  4  visibility mask to `display`; bit3 = digit 1, bit2 = digit 2, bit1 = digit 3, bit0 = digit 4.
- o_Enable_Dot  out  1  dot enable to `display`; `display` shows it only on digit 2.
- o_Frame  out  1  one-cycle strobe on the first cycle of slot 0 (digit 1).

Behaviour:
- State registers:
  - slot counter `cnt`, 0..SCAN_DIV-1
  - select `sel`, 2 bits
  - blink phase `ph`, 1 = visible
  - edit-active history `ed_q`
- Reset, applied at the clock edge with i_Reset = 1:
  - cnt = 0, sel = 00, ph = 1, ed_q = 0.
  - Outputs: o_Select = 00, o_Enable_Digits = 0000, o_Enable_Dot = 0, o_Frame = 0.
  - Reset has priority over every other event; reset mid-slot restarts at slot 0, cnt = 0.
- Scan:
  - cnt increments every cycle.
  - At cnt = SCAN_DIV-1, cnt wraps to 0 and sel increments mod 4 (11 → 00).
  - One full frame = 4·SCAN_DIV cycles.
- Outputs are registered and consistent with state in the same cycle: o_Select = sel always.
- Dead time:
  - While cnt < DEAD_CYCLES, o_Enable_Digits = 0000 and o_Enable_Dot = 0.
  - Otherwise o_Enable_Digits = vis_mask and o_Enable_Dot = dot.
  - With DEAD_CYCLES = 0, no blanking occurs.
- o_Frame = 1 exactly when sel = 00 and cnt = 0, excluding the reset cycle itself. The first pulse occurs 4·SCAN_DIV cycles after reset release.
- Blink phase:
  - ph toggles on each i_Tick_Half_Sec.
  - Edit entry: in the cycle after the edit-active signal (i_Edit_Hours | i_Edit_Minutes) rises from 0, ph is forced to 1. This entry takes priority over a coincident tick; the edit pair is visible immediately for a full half-second.
- Visibility mask (vis_mask):
  - No edit: 1111.
  - i_Edit_Hours = 1 and ph = 0: 0011.
  - i_Edit_Minutes = 1 (hours not editing) and ph = 0: 1100.
  - Both asserted: hours take priority, so minutes stay visible.
  - ph = 1: 1111.
- Dot:
  - No edit: dot = ph (colon blinks at 1 Hz, 50% duty).
  - Edit active: dot = 1 (steady).
- Edit inputs and ticks take effect on the next cycle's outputs (1-cycle latency). A change during dead time takes effect when dead time ends.

Decomposition:
- Shared package `display_pkg` holds:
  - slot encodings SEL_DIG1..SEL_DIG4 (00..11)
  - mask constants MASK_ALL = 1111, MASK_HOURS = 1100, MASK_MINS = 0011
  - parameter legality checks
- One natural sub-module, `scan_prescaler`: the mod-SCAN_DIV counter with wrap strobe, reusable for the timebase.

Test Plan (SCAN_DIV = 8, DEAD_CYCLES = 2):
- Reset held 3 cycles, then released:
  - Cycles 0–1 after release: Select 00, Enable 0000.
  - Cycles 2–7: Enable 1111.
  - Cycle 8: Select 01, Enable 0000.
  - Cycle 32: Select 00 and Frame = 1.
- No edit, tick strobed at cycle 10:
  - Cycle 11 onward: Dot 0 outside dead time, Dot 0 during dead time.
  - Second tick: Dot 1 on the next non-dead cycle.
- Edit_Hours rises together with a tick:
  - ph stays 1, Enable 1111.
  - Next tick: Enable 0011 during slots with cnt ≥ 2, Dot 1.
  - Next tick: 1111.
- Edit_Hours and Edit_Minutes both high, ph = 0 → Enable 0011 (minutes shown).
  - Drop Edit_Hours → Enable 1100 next cycle.
- Reset asserted at sel = 10, cnt = 5 → next cycle Select 00, Enable 0000, Dot 0; scan restarts at cnt = 0.
- Chain into `display` with digits 2, 3, 5, 4, no edit, ph = 1 → over one frame, segments show 2, 3 with dot, 5, 4 in turn; o_Digits = 0001, 0010, 0100, 1000, and all-zero during each dead time.
